// File: rtl/muldiv_alu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// default ROB tag width and the divider state type.
package muldiv_alu_pkg;

  localparam int unsigned ROB_WIDTH_BIT = 4;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    DivIdle,
    DivRun,
    DivDone
  } div_state_e;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on operand magnitudes and fixes signs when the result is presented.
// start is taken only in IDLE; the result is held in DONE until ack.
module muldiv_div_unit
  import muldiv_alu_pkg::*;
#(
  parameter int unsigned ROB_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,        // funct3[1:0]: bit0 = unsigned, bit1 = remainder
  input  logic [31:0]      r1,
  input  logic [31:0]      r2,
  input  logic [ROB_W-1:0] rob_id,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [ROB_W-1:0] res_rob,
  output logic [31:0]      res_value
);

  div_state_e state_q, state_d;

  logic [4:0]       cnt_q;
  logic [32:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             want_rem_q;
  logic             by_zero_q;
  logic [ROB_W-1:0] rob_q;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, rem_next;
  logic [31:0] quo_next, quo_fix, rem_fix;
  logic        ge;

  // Operand conditioning at start: magnitudes and result sign bookkeeping
  always_comb begin
    a_neg = ~op[0] & r1[31];
    b_neg = ~op[0] & r2[31];
    a_mag = a_neg ? (32'd0 - r1) : r1;
    b_mag = b_neg ? (32'd0 - r2) : r2;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", leaving the remainder equal to |rs1|.
  always_comb begin
    shifted  = {rem_q[31:0], quo_q[31]};
    ge       = (shifted >= {1'b0, dvs_q});
    rem_next = ge ? (shifted - {1'b0, dvs_q}) : shifted;
    quo_next = {quo_q[30:0], ge};
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= DivIdle;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = DivIdle;
    end else begin
      unique case (state_q)
        DivIdle: if (start)         state_d = DivRun;
        DivRun:  if (cnt_q == 5'd31) state_d = DivDone;
        DivDone: if (ack)           state_d = DivIdle;
        default:                    state_d = DivIdle;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != DivIdle);
    done = (state_q == DivDone);
  end

  // Datapath: load on start, iterate while running
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
      by_zero_q  <= 1'b0;
      rob_q      <= '0;
    end else if (rdy_in) begin
      if (state_q == DivIdle && start && !flush) begin
        cnt_q      <= '0;
        rem_q      <= '0;
        quo_q      <= a_mag;
        dvs_q      <= b_mag;
        neg_quo_q  <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
        want_rem_q <= op[1];
        by_zero_q  <= (r2 == 32'd0);
        rob_q      <= rob_id;
      end else if (state_q == DivRun) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  // Sign fix-up; overflow (0x80000000 / -1) falls out naturally as 0x80000000 rem 0
  always_comb begin
    quo_fix   = neg_quo_q ? (32'd0 - quo_q) : quo_q;
    rem_fix   = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    res_rob   = rob_q;
    res_value = want_rem_q ? rem_fix : (by_zero_q ? 32'hFFFF_FFFF : quo_fix);
  end

endmodule

// File: rtl/muldiv_alu.sv
// RV32M execution unit: pipelined multiplier plus iterative divider, results
// tagged by ROB id and drained through a credit-protected result FIFO.
module muldiv_alu
  import muldiv_alu_pkg::*;
#(
  parameter int unsigned ROB_W      = ROB_WIDTH_BIT,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned OUT_DEPTH  = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_r1,
  input  logic [31:0]      in_r2,
  input  logic [ROB_W-1:0] in_rob_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROB_W-1:0] out_rob_id,
  output logic [31:0]      out_value
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic accept, mul_start, div_start, pop;

  // Multiplier pipe
  logic [MUL_STAGES-1:0] mul_vld_q;
  logic [ROB_W-1:0]      mul_rob_q [MUL_STAGES];
  logic [31:0]           mul_val_q [MUL_STAGES];
  logic                  a_sgn, b_sgn;
  logic [63:0]           a_ext, b_ext, prod;
  logic [31:0]           mul_res;
  logic [2:0]            mul_live;
  logic                  mul_last;

  // Divider handshake
  logic             div_busy, div_done, div_ack;
  logic [ROB_W-1:0] div_rob;
  logic [31:0]      div_value;

  // Result FIFO
  logic [ROB_W-1:0] q_rob_q [OUT_DEPTH];
  logic [31:0]      q_val_q [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             enq;
  logic [ROB_W-1:0] enq_rob;
  logic [31:0]      enq_val;
  logic [7:0]       used;

  // Credit check: every accepted op owns a queue slot until it is popped
  always_comb begin
    mul_live = '0;
    for (int k = 0; k < MUL_STAGES; k++) begin
      mul_live = mul_live + 3'(mul_vld_q[k]);
    end
    used      = 8'(count_q) + 8'(mul_live) + 8'(div_busy);
    in_ready  = rst_in && rdy_in && !flush && (used < 8'(OUT_DEPTH)) &&
                (!is_div_op(in_op) || !div_busy);
    accept    = in_valid && in_ready;
    mul_start = accept && !is_div_op(in_op);
    div_start = accept && is_div_op(in_op);
  end

  // One 33x33 signed product covers every MUL variant; computed in 64 bits
  always_comb begin
    a_sgn   = (in_op == MD_MULH) || (in_op == MD_MULHSU);
    b_sgn   = (in_op == MD_MULH);
    a_ext   = {{32{a_sgn & in_r1[31]}}, in_r1};
    b_ext   = {{32{b_sgn & in_r2[31]}}, in_r2};
    prod    = a_ext * b_ext;
    mul_res = (in_op == MD_MUL) ? prod[31:0] : prod[63:32];
  end

  // Multiplier stage valids
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mul_vld_q <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        mul_vld_q <= '0;
      end else begin
        mul_vld_q[0] <= mul_start;
        for (int k = 1; k < MUL_STAGES; k++) begin
          mul_vld_q[k] <= mul_vld_q[k-1];
        end
      end
    end
  end

  // Multiplier stage payload; qualified by the valids above
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      mul_rob_q[0] <= in_rob_id;
      mul_val_q[0] <= mul_res;
      for (int k = 1; k < MUL_STAGES; k++) begin
        mul_rob_q[k] <= mul_rob_q[k-1];
        mul_val_q[k] <= mul_val_q[k-1];
      end
    end
  end

  muldiv_div_unit #(
    .ROB_W (ROB_W)
  ) u_div (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush     (flush),
    .start     (div_start),
    .op        (in_op[1:0]),
    .r1        (in_r1),
    .r2        (in_r2),
    .rob_id    (in_rob_id),
    .ack       (div_ack),
    .busy      (div_busy),
    .done      (div_done),
    .res_rob   (div_rob),
    .res_value (div_value)
  );

  // Enqueue arbitration: the multiplier cannot stall, so it wins a collision
  always_comb begin
    mul_last = mul_vld_q[MUL_STAGES-1];
    enq      = mul_last || div_done;
    div_ack  = div_done && !mul_last;
    enq_rob  = mul_last ? mul_rob_q[MUL_STAGES-1] : div_rob;
    enq_val  = mul_last ? mul_val_q[MUL_STAGES-1] : div_value;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(enq) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk_in) begin
    if (rdy_in && enq && !flush) begin
      q_rob_q[wr_ptr_q] <= enq_rob;
      q_val_q[wr_ptr_q] <= enq_val;
    end
  end

  // Head presentation; payload forced to zero while empty
  always_comb begin
    out_valid  = rdy_in && (count_q != '0);
    pop        = out_valid && out_ready;
    out_rob_id = (count_q != '0) ? q_rob_q[rd_ptr_q] : '0;
    out_value  = (count_q != '0) ? q_val_q[rd_ptr_q] : '0;
  end

endmodule
